alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Bus master for the 16-bit alu. Takes 16/32-bit op requests over a valid/ready handshake and drives alu operands, select and enable.
//  Pulses enable once per 16-bit pass and captures data/carry_out/zero_flag; 32-bit ops run as two passes with carry chained.
//  Sits between the control unit and the alu; holds the result until the control unit takes it.
// PARAMETERS
//  WIDTH      16  alu word width; wide ops are 2*WIDTH
//  SETUP_CYC  1   cycles operands are held with enable low before each pass (>=1)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   async active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   request accepted when valid&&ready
//  req_op         in   3   0 add,1 sub,2 and,3 or,4 xor,5 not,6 inc,7 dec
//  req_wide       in   1   1 = 32-bit op, 0 = 16-bit
//  req_carry      in   1   carry_in for add (low pass)
//  req_a, req_b   in   32  operands; narrow ops use [15:0]
//  rsp_valid      out  1   result valid, held until rsp_ready
//  rsp_ready      in   1   consumer takes result
//  rsp_result     out  32  result; narrow ops zero-extend
//  rsp_carry      out  1   carry_out of last pass
//  rsp_zero       out  1   1 if all result bits of the op width are 0
//  alu_in_1       out  16  alu operand 1
//  alu_in_2       out  16  alu operand 2
//  alu_select     out  3   alu operation
//  alu_enable     out  1   alu enable; alu evaluates on rising edge of this signal
//  alu_carry_in   out  1   alu carry in
//  alu_data       in   16  alu result; Z while enable low
//  alu_carry_out  in   1   alu carry out
//  alu_zero       in   1   alu zero flag
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0 except req_ready=1.
//  Reset mid-op aborts immediately: enable drops, no rsp issued.
//  FSM: IDLE -> SETUP_LO -> EXEC_LO -> [SETUP_HI -> EXEC_HI] -> DONE -> IDLE.
//  - IDLE: req_ready=1; on accept, register the request and drive pass-0 operands.
//  - SETUP_x: operands stable, enable=0, for SETUP_CYC cycles.
//  - EXEC_x: enable=1 for exactly one cycle; capture alu_data/carry/zero on the closing edge.
//  - DONE: rsp_valid=1; outputs stable until rsp_ready; then IDLE.
//  Enable always returns low between passes so the alu re-evaluates.
//  alu_in_*, select and carry_in never change while enable=1.
//  Capture only in EXEC states; alu_data is never sampled while enable=0.
//  Latency (SETUP_CYC=1): narrow rsp_valid 2 edges after accept; wide 4 edges.
//  req_ready=0 outside IDLE. A new request during DONE waits one cycle.
//  Narrow: alu_select=req_op and in_2=b[15:0]; carry_in=req_carry for add, else 0.
//  Wide pass mapping (lo pass / hi pass, hi carry_in = captured lo carry_out):
//  - add: ADD a,b, cin=req_carry / ADD, chained.
//  - sub: ADD a,~b, cin=1 / ADD a,~b, chained; rsp_carry=1 means no borrow.
//  - inc: ADD a,0, cin=1 / ADD a,0, chained.
//  - dec: ADD a,0xFFFF, cin=0 / ADD a,0xFFFF, chained.
//  - and/or/xor/not: same op on each half, cin=0; rsp_carry = hi-pass carry_out (0).
//  Wide rsp_zero = zero_lo & zero_hi. Narrow: rsp_result[31:16]=0, rsp_zero = alu_zero.
//  Narrow sub/dec report the raw alu carry_out, i.e. the borrow bit.
// STRUCTURE
//  alu_pkg: op encodings (ALU_ADD..ALU_DEC), state enum, WIDTH default.
//  Sub-module alu_pass_map: combinational {op,wide,pass,a,b,carry} -> {select,in_1,in_2,carry_in}.
//  Top holds FSM, setup counter, capture registers.
// TESTING
//  narrow add 0x1234+0x0001, carry 1 -> 0x00001236, c=0, z=0; enable high exactly 1 cycle.
//  wide add 0x0000FFFF+0x00000001 -> 0x00010000, c=0, z=0; two enable pulses with a low gap.
//  wide sub 0x00010000-0x00000001 -> 0x0000FFFF, c=1; wide dec 0 -> 0xFFFFFFFF, c=0.
//  wide inc 0xFFFFFFFF -> 0x00000000, c=1, z=1; narrow and 0xF0F0&0x0F0F -> 0, z=1.
//  rsp_ready low 5 cycles in DONE -> rsp fields stable, req_ready=0, no extra enable pulse.
//  rst_n low during EXEC_HI -> enable 0 at once, rsp_valid 0, req_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the alu bus master: alu op encodings, sequencer states, word width.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_INC = 3'd6,
    ALU_DEC = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP_LO = 3'd1,
    ST_EXEC_LO  = 3'd2,
    ST_SETUP_HI = 3'd3,
    ST_EXEC_HI  = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_pass_map.sv
// Maps a request plus pass index onto the alu select/operands/carry for that pass.
// Wide arithmetic is rewritten as chained ADD passes so the carry propagates between halves.
module alu_pass_map
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_op_e              op,
  input  logic                 wide,
  input  logic                 pass,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0]   b,
  input  logic                 carry,
  output alu_op_e              select,
  output logic [WIDTH-1:0]     in_1,
  output logic [WIDTH-1:0]     in_2,
  output logic                 carry_in
);

  logic [WIDTH-1:0] half_a;
  logic [WIDTH-1:0] half_b;

  assign half_a = pass ? a[2*WIDTH-1:WIDTH] : a[WIDTH-1:0];
  assign half_b = pass ? b[2*WIDTH-1:WIDTH] : b[WIDTH-1:0];

  // `carry` is req_carry on the low pass and the captured low carry_out on the high pass.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch can be inferred.
    select   = op;
    in_1     = half_a;
    in_2     = half_b;
    carry_in = 1'b0;
    if (!wide) begin
      carry_in = (op == ALU_ADD) ? carry : 1'b0;
    end else begin
      case (op)
        ALU_ADD: carry_in = carry;
        ALU_SUB: begin
          select   = ALU_ADD;
          in_2     = ~half_b;
          carry_in = pass ? carry : 1'b1;
        end
        ALU_INC: begin
          select   = ALU_ADD;
          in_2     = '0;
          carry_in = pass ? carry : 1'b1;
        end
        ALU_DEC: begin
          select   = ALU_ADD;
          in_2     = '1;
          carry_in = pass ? carry : 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Bus master for the 16-bit alu: accepts 16/32-bit op requests, runs one or two enable
// pulses with setup gaps, captures the alu outputs and holds the response until taken.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int SETUP_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic                 req_wide,
  input  logic                 req_carry,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic [WIDTH-1:0]     alu_in_1,
  output logic [WIDTH-1:0]     alu_in_2,
  output logic [2:0]           alu_select,
  output logic                 alu_enable,
  output logic                 alu_carry_in,
  input  logic [WIDTH-1:0]     alu_data,
  input  logic                 alu_carry_out,
  input  logic                 alu_zero
);

  localparam int CNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);

  seq_state_e            state;
  alu_op_e               op_q;
  logic                  wide_q;
  logic [2*WIDTH-1:0]    a_q;
  logic [2*WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]      data_lo_q;
  logic                  zero_lo_q;
  logic [CNT_W-1:0]      setup_cnt;

  logic                  in_idle;
  alu_op_e               map_op;
  logic                  map_wide;
  logic [2*WIDTH-1:0]    map_a;
  logic [2*WIDTH-1:0]    map_b;
  logic                  map_carry;
  alu_op_e               map_select;
  logic [WIDTH-1:0]      map_in_1;
  logic [WIDTH-1:0]      map_in_2;
  logic                  map_carry_in;

  // In IDLE the map sees the live request (pass 0); afterwards only the high pass is loaded,
  // and only on the edge closing EXEC_LO, when alu_carry_out is valid.
  assign in_idle   = (state == ST_IDLE);
  assign map_op    = in_idle ? alu_op_e'(req_op) : op_q;
  assign map_wide  = in_idle ? req_wide : wide_q;
  assign map_a     = in_idle ? req_a : a_q;
  assign map_b     = in_idle ? req_b : b_q;
  assign map_carry = in_idle ? req_carry : alu_carry_out;

  alu_pass_map #(.WIDTH(WIDTH)) u_pass_map (
    .op       (map_op),
    .wide     (map_wide),
    .pass     (!in_idle),
    .a        (map_a),
    .b        (map_b),
    .carry    (map_carry),
    .select   (map_select),
    .in_1     (map_in_1),
    .in_2     (map_in_2),
    .carry_in (map_carry_in)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= ALU_ADD;
      wide_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      data_lo_q    <= '0;
      zero_lo_q    <= 1'b0;
      setup_cnt    <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      alu_in_1     <= '0;
      alu_in_2     <= '0;
      alu_select   <= '0;
      alu_enable   <= 1'b0;
      alu_carry_in <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q         <= alu_op_e'(req_op);
            wide_q       <= req_wide;
            a_q          <= req_a;
            b_q          <= req_b;
            alu_select   <= map_select;
            alu_in_1     <= map_in_1;
            alu_in_2     <= map_in_2;
            alu_carry_in <= map_carry_in;
            req_ready    <= 1'b0;
            setup_cnt    <= '0;
            state        <= ST_SETUP_LO;
          end
        end
        ST_SETUP_LO, ST_SETUP_HI: begin
          if (setup_cnt == SETUP_LAST) begin
            alu_enable <= 1'b1;
            state      <= (state == ST_SETUP_LO) ? ST_EXEC_LO : ST_EXEC_HI;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        ST_EXEC_LO: begin
          alu_enable <= 1'b0;
          if (wide_q) begin
            data_lo_q    <= alu_data;
            zero_lo_q    <= alu_zero;
            alu_select   <= map_select;
            alu_in_1     <= map_in_1;
            alu_in_2     <= map_in_2;
            alu_carry_in <= map_carry_in;
            setup_cnt    <= '0;
            state        <= ST_SETUP_HI;
          end else begin
            rsp_result <= {{WIDTH{1'b0}}, alu_data};
            rsp_carry  <= alu_carry_out;
            rsp_zero   <= alu_zero;
            rsp_valid  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_EXEC_HI: begin
          alu_enable <= 1'b0;
          rsp_result <= {alu_data, data_lo_q};
          rsp_carry  <= alu_carry_out;
          rsp_zero   <= zero_lo_q & alu_zero;
          rsp_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural alu device, directed corner cases,
// randomized ops against an arithmetic reference model, back-pressure and mid-op reset.
module tb_alu_sequencer;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3;
  localparam int OP_XOR = 4, OP_NOT = 5, OP_INC = 6, OP_DEC = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic        req_wide, req_carry;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_zero;
  logic [15:0] alu_in_1, alu_in_2;
  logic [2:0]  alu_select;
  logic        alu_enable, alu_carry_in;
  logic [15:0] alu_data;
  logic        alu_carry_out, alu_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_wide      (req_wide),
    .req_carry     (req_carry),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_carry     (rsp_carry),
    .rsp_zero      (rsp_zero),
    .alu_in_1      (alu_in_1),
    .alu_in_2      (alu_in_2),
    .alu_select    (alu_select),
    .alu_enable    (alu_enable),
    .alu_carry_in  (alu_carry_in),
    .alu_data      (alu_data),
    .alu_carry_out (alu_carry_out),
    .alu_zero      (alu_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural alu: evaluates on the rising edge of enable, drives junk while enable is low.
  logic [15:0] alu_val = '0;
  logic        alu_c = 1'b0, alu_z = 1'b0;
  logic [15:0] lat_in1 = '0, lat_in2 = '0;
  logic [2:0]  lat_sel = '0;
  logic        lat_cin = 1'b0;

  always @(posedge alu_enable) begin
    logic [16:0] s;
    lat_in1 = alu_in_1;
    lat_in2 = alu_in_2;
    lat_sel = alu_select;
    lat_cin = alu_carry_in;
    s = '0;
    alu_c = 1'b0;
    case (alu_select)
      3'd0: begin s = {1'b0, alu_in_1} + {1'b0, alu_in_2} + {16'b0, alu_carry_in}; alu_val = s[15:0]; alu_c = s[16]; end
      3'd1: begin alu_val = alu_in_1 - alu_in_2; alu_c = (alu_in_1 < alu_in_2); end
      3'd2: alu_val = alu_in_1 & alu_in_2;
      3'd3: alu_val = alu_in_1 | alu_in_2;
      3'd4: alu_val = alu_in_1 ^ alu_in_2;
      3'd5: alu_val = ~alu_in_1;
      3'd6: begin alu_val = alu_in_1 + 16'd1; alu_c = (alu_in_1 == 16'hFFFF); end
      default: begin alu_val = alu_in_1 - 16'd1; alu_c = (alu_in_1 == 16'h0000); end
    endcase
    alu_z = (alu_val == 16'h0000);
  end

  assign alu_data      = alu_enable ? alu_val : 16'hDEAD;
  assign alu_carry_out = alu_enable ? alu_c : 1'b1;
  assign alu_zero      = alu_enable ? alu_z : 1'b1;

  // Enable pulse monitor: each pulse one cycle wide, alu inputs frozen while enable is high.
  int pulses = 0;
  int high_run = 0;
  always @(negedge clk) begin
    if (alu_enable) begin
      high_run++;
      check("in_stable", {alu_in_1, alu_in_2}, {lat_in1, lat_in2});
      check("sel_stable", {28'b0, alu_select, alu_carry_in}, {28'b0, lat_sel, lat_cin});
    end else if (high_run > 0) begin
      check("pulse_width", high_run, 1);
      pulses++;
      high_run = 0;
    end
  end

  // Reference: plain arithmetic on the full op width. Returns {zero, carry, result}.
  function automatic logic [33:0] ref_model(input int op, input bit wide, input bit cin,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s33;
    logic [16:0] s17;
    logic [31:0] r;
    logic [15:0] aa, bb, rr;
    logic        c;
    r = '0; c = 1'b0;
    if (wide) begin
      case (op)
        OP_ADD: begin s33 = {1'b0, a} + {1'b0, b} + {32'b0, cin}; r = s33[31:0]; c = s33[32]; end
        OP_SUB: begin r = a - b; c = (a >= b); end
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_XOR: r = a ^ b;
        OP_NOT: r = ~a;
        OP_INC: begin r = a + 32'd1; c = (a == 32'hFFFF_FFFF); end
        default: begin r = a - 32'd1; c = (a != 32'd0); end
      endcase
    end else begin
      aa = a[15:0];
      bb = b[15:0];
      case (op)
        OP_ADD: begin s17 = {1'b0, aa} + {1'b0, bb} + {16'b0, cin}; rr = s17[15:0]; c = s17[16]; end
        OP_SUB: begin rr = aa - bb; c = (aa < bb); end
        OP_AND: rr = aa & bb;
        OP_OR:  rr = aa | bb;
        OP_XOR: rr = aa ^ bb;
        OP_NOT: rr = ~aa;
        OP_INC: begin rr = aa + 16'd1; c = (aa == 16'hFFFF); end
        default: begin rr = aa - 16'd1; c = (aa == 16'h0000); end
      endcase
      r = {16'b0, rr};
    end
    return {(r == 32'd0), c, r};
  endfunction

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_op(input int op, input bit wide, input bit cin, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input string tag);
    logic [33:0] exp;
    logic [31:0] res0;
    int edges, p0;
    bit got;
    exp = ref_model(op, wide, cin, a, b);
    p0 = pulses;
    req_valid = 1'b1; req_op = op[2:0]; req_wide = wide; req_carry = cin; req_a = a; req_b = b;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin got = 1'b1; break; end
      sample();
    end
    check({tag, "/accept"}, {31'b0, got}, 32'd1);
    if (!got) begin req_valid = 1'b0; return; end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 3'($urandom); req_carry = ~cin;
    edges = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      sample();
      if (rsp_valid) begin got = 1'b1; break; end
    end
    check({tag, "/rsp_seen"}, {31'b0, got}, 32'd1);
    if (!got) return;
    check({tag, "/latency"}, edges, wide ? 32'd4 : 32'd2);
    check({tag, "/result"}, rsp_result, exp[31:0]);
    check({tag, "/carry"}, {31'b0, rsp_carry}, {31'b0, exp[32]});
    check({tag, "/zero"}, {31'b0, rsp_zero}, {31'b0, exp[33]});
    check({tag, "/pulses"}, pulses - p0, wide ? 32'd2 : 32'd1);
    check({tag, "/ready_busy"}, {31'b0, req_ready}, 32'd0);
    res0 = rsp_result;
    if (hold > 0) begin
      req_valid = 1'b1; req_wide = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      sample();
      check({tag, "/hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "/hold_result"}, rsp_result, res0);
      check({tag, "/hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    check({tag, "/hold_pulses"}, pulses - p0, wide ? 32'd2 : 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "/rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "/idle_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit got;
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_wide = 1'b0; req_carry = 1'b0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    check("reset/req_ready", {31'b0, req_ready}, 32'd1);
    check("reset/rsp", {rsp_result[29:0], rsp_valid, rsp_carry | rsp_zero}, 32'd0);
    check("reset/alu", {alu_in_1, alu_in_2}, 32'd0);
    check("reset/alu_ctl", {27'b0, alu_select, alu_enable, alu_carry_in}, 32'd0);
    sample();
    rst_n = 1'b1;
    sample();

    do_op(OP_ADD, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_0001, 0, "n_add");
    do_op(OP_ADD, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1, "w_add");
    do_op(OP_SUB, 1'b1, 1'b0, 32'h0001_0000, 32'h0000_0001, 0, "w_sub");
    do_op(OP_DEC, 1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 0, "w_dec");
    do_op(OP_INC, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 0, "w_inc");
    do_op(OP_AND, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0F0F, 5, "n_and_hold");
    do_op(OP_SUB, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0002, 0, "n_sub_borrow");
    do_op(OP_DEC, 1'b0, 1'b0, 32'hABCD_0000, 32'h0000_0000, 0, "n_dec_borrow");
    do_op(OP_NOT, 1'b1, 1'b1, 32'h0F0F_00FF, 32'h0000_0000, 2, "w_not");

    // Reset while the high pass is executing.
    p0 = pulses;
    req_valid = 1'b1; req_op = 3'(OP_ADD); req_wide = 1'b1; req_carry = 1'b0;
    req_a = 32'h1111_2222; req_b = 32'h3333_4444;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (alu_enable && pulses == p0 + 1) begin got = 1'b1; break; end
    end
    check("rst/reach_exec_hi", {31'b0, got}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst/enable_drop", {31'b0, alu_enable}, 32'd0);
    check("rst/no_rsp", {31'b0, rsp_valid}, 32'd0);
    check("rst/ready", {31'b0, req_ready}, 32'd1);
    sample();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rst/after", {29'b0, rsp_valid, req_ready, alu_enable}, 32'd2);
    end
    check("rst/pulses", pulses - p0, 32'd2);

    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom, $urandom,
            int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
